// File: rtl/dac_req_arbiter.sv
// Round-robin arbiter sharing one serial DAC write engine between NUM_REQ requesters.
// Optional code saturation to [CLAMP_LO, CLAMP_HI] is built when DAC_REQ_CLAMP_EN is defined.
module dac_req_arbiter #(
    parameter int                NUM_REQ  = 4,
    parameter int                DATA_W   = 12,
    parameter int                MIN_GAP  = 8,
    parameter int                BUSY_TMO = 16,
    parameter logic [DATA_W-1:0] CLAMP_LO = '0,
    parameter logic [DATA_W-1:0] CLAMP_HI = '1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          ack,
    output logic                        dac_start,
    output logic [DATA_W-1:0]           dac_data,
    input  logic                        dac_busy,
    output logic                        arb_busy,
    output logic [2:0]                  last_grant,
    input  logic                        err_clr,
    output logic                        err_timeout,
    output logic                        clamp_hit
);

    localparam int TMO_W = $clog2(BUSY_TMO + 2);
    localparam int GAP_W = $clog2(MIN_GAP + 2);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE,
        GAP
    } state_t;

    state_t             state;
    logic [2:0]         rr_ptr;
    logic [TMO_W-1:0]   tmo_cnt;
    logic [GAP_W-1:0]   gap_cnt;

    logic [3:0]         pick;
    logic               win_vld;
    logic [2:0]         win_idx;
    logic [DATA_W-1:0]  raw_code;
    logic [DATA_W-1:0]  code_sel;
    logic               hit_sel;

    // Returns {found, index}; lower rotation offsets overwrite higher ones, so the
    // first asserted request at or after ptr wins.
    function automatic logic [3:0] rr_pick(input logic [NUM_REQ-1:0] r, input logic [2:0] ptr);
        logic [3:0] res;
        int         idx;
        res = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            for (int i = 0; i < NUM_REQ; i++)
                if (i == idx && r[i]) res = {1'b1, 3'(i)};
        end
        return res;
    endfunction

    // Unsigned saturation; MSB of the result flags that the code was altered.
    function automatic logic [DATA_W:0] sat_code(input logic [DATA_W-1:0] c);
        if (c > CLAMP_HI) return {1'b1, CLAMP_HI};
        if (c < CLAMP_LO) return {1'b1, CLAMP_LO};
        return {1'b0, c};
    endfunction

    assign pick    = rr_pick(req, rr_ptr);
    assign win_vld = pick[3];
    assign win_idx = pick[2:0];

    always_comb begin
        raw_code = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (win_idx == 3'(i)) raw_code = req_data[i*DATA_W +: DATA_W];
    end

    always_comb begin
`ifdef DAC_REQ_CLAMP_EN
        {hit_sel, code_sel} = sat_code(raw_code);
`else
        hit_sel  = 1'b0;
        code_sel = raw_code;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            ack         <= '0;
            dac_start   <= 1'b0;
            dac_data    <= '0;
            arb_busy    <= 1'b0;
            last_grant  <= '0;
            err_timeout <= 1'b0;
            clamp_hit   <= 1'b0;
            tmo_cnt     <= '0;
            gap_cnt     <= '0;
        end else begin
            ack       <= '0;
            dac_start <= 1'b0;
            clamp_hit <= 1'b0;
            // A timeout set later in this block overrides the clear.
            if (err_clr) err_timeout <= 1'b0;

            case (state)
                IDLE: begin
                    if (win_vld) begin
                        dac_data   <= code_sel;
                        clamp_hit  <= hit_sel;
                        ack        <= NUM_REQ'(1) << win_idx;
                        last_grant <= win_idx;
                        rr_ptr     <= (int'(win_idx) == NUM_REQ - 1) ? 3'd0 : win_idx + 3'd1;
                        arb_busy   <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    dac_start <= 1'b1;
                    tmo_cnt   <= TMO_W'(BUSY_TMO);
                    state     <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (dac_busy) begin
                        state <= WAIT_DONE;
                    end else if (tmo_cnt <= TMO_W'(1)) begin
                        tmo_cnt     <= '0;
                        err_timeout <= 1'b1;
                        gap_cnt     <= GAP_W'(MIN_GAP);
                        state       <= GAP;
                    end else begin
                        tmo_cnt <= tmo_cnt - TMO_W'(1);
                    end
                end
                WAIT_DONE: begin
                    if (!dac_busy) begin
                        gap_cnt <= GAP_W'(MIN_GAP);
                        state   <= GAP;
                    end
                end
                GAP: begin
                    // MIN_GAP of 0 or 1 both leave after a single cycle here.
                    if (gap_cnt <= GAP_W'(1)) begin
                        gap_cnt  <= '0;
                        arb_busy <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end
                default: begin
                    arb_busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule
